// File: rtl/dram_loader_pkg.sv
// Shared DRAM constants, word packing and diagnostic sub-function codes for the
// dispatch-RAM loader (also imported by the IR board).
package dram_loader_pkg;

  localparam int DRAM_SIZE  = 512;
  localparam int DRAM_WIDTH = 15;
  localparam int DRAM_AW    = $clog2(DRAM_SIZE);
  localparam int EBUS_WIDTH = 36;

  // Bit offsets use the PDP-10 convention: bit 0 is the most significant.
  localparam int F_A_LO    = 0;
  localparam int F_A_HI    = 2;
  localparam int F_B_LO    = 3;
  localparam int F_B_HI    = 5;
  localparam int F_J_LO    = 0;
  localparam int F_J_HI    = 3;
  localparam int F_ADR_LO  = 27;
  localparam int F_ADR_HI  = 35;
  localparam int F_AUTOINC = 0;
  localparam int F_BADPAR  = 1;

  typedef logic [0:DRAM_WIDTH-1] dram_word_t;
  typedef logic [DRAM_AW-1:0]    dram_addr_t;
  typedef logic [0:EBUS_WIDTH-1] ebus_word_t;

  typedef enum logic [2:0] {
    SUB_LD_ADR       = 3'd0,
    SUB_LD_AB        = 3'd1,
    SUB_LD_J14       = 3'd2,
    SUB_LD_J7_COMMIT = 3'd3,
    SUB_CLR_ERR      = 3'd4,
    SUB_RD           = 3'd5,
    SUB_RSV6         = 3'd6,
    SUB_RSV7         = 3'd7
  } diag_sub_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_VERIFY
  } ld_state_e;

  // Word layout: A[0:2] B[3:5] P[6] J1_4[7:10] J7_10[11:14].
  function automatic dram_word_t pack_word(input logic [2:0] a, input logic [2:0] b,
                                           input logic p, input logic [3:0] j14,
                                           input logic [3:0] j710);
    return {a, b, p, j14, j710};
  endfunction

endpackage

// File: rtl/dram_loader_if.sv
// Diagnostic EBUS load port plus the DRAM write/readback port owned by the loader.
interface dram_loader_if;
  import dram_loader_pkg::*;

  logic       diag_load_func_05x;
  logic [2:0] diag_sel;
  ebus_word_t ebus_data;
  logic       cpu_run;
  dram_word_t dram_dout;

  dram_addr_t dram_addr;
  logic       dram_own;
  dram_word_t dram_din;
  logic       dram_we;
  logic       busy;
  logic       err_verify;
  logic       err_run;
  dram_word_t rdback;

  modport slave (
    input  diag_load_func_05x, diag_sel, ebus_data, cpu_run, dram_dout,
    output dram_addr, dram_own, dram_din, dram_we, busy, err_verify, err_run, rdback
  );

  modport master (
    output diag_load_func_05x, diag_sel, ebus_data, cpu_run, dram_dout,
    input  dram_addr, dram_own, dram_din, dram_we, busy, err_verify, err_run, rdback
  );
endinterface

// File: rtl/dram_parity_gen.sv
// Odd-parity bit for the 14 data bits of a DRAM word; invert forces bad parity.
module dram_parity_gen (
  input  logic [13:0] data,
  input  logic        invert,
  output logic        par
);
  assign par = ~(^data) ^ invert;
endmodule

// File: rtl/dram_loader.sv
// Diagnostic DRAM loader: assembles A/B/J fields, writes the dispatch RAM,
// reads the word back for verification and optionally steps the address.
module dram_loader
  import dram_loader_pkg::*;
(
  input logic          clk,
  input logic          rst_n,
  dram_loader_if.slave bus
);

  ld_state_e  state_q, state_d;
  dram_addr_t addr_q, addr_d;
  logic       auto_inc_q, auto_inc_d;
  logic       force_bad_par_q, force_bad_par_d;
  logic [2:0] a_q, a_d, b_q, b_d;
  logic [3:0] j14_q, j14_d, j710_q, j710_d;
  logic       is_commit_q, is_commit_d;
  logic       err_verify_q, err_verify_d;
  logic       err_run_q, err_run_d;
  dram_word_t rdback_q, rdback_d;

  logic       par;
  dram_word_t word;
  diag_sub_e  sub;
  logic       unused_ebus;

  dram_parity_gen u_parity (
    .data   ({a_q, b_q, j14_q, j710_q}),
    .invert (force_bad_par_q),
    .par    (par)
  );

  assign word        = pack_word(a_q, b_q, par, j14_q, j710_q);
  assign sub         = diag_sub_e'(bus.diag_sel);
  assign unused_ebus = ^bus.ebus_data[F_B_HI+1:F_ADR_LO-1];

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of every other flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      addr_q          <= '0;
      auto_inc_q      <= 1'b0;
      force_bad_par_q <= 1'b0;
      a_q             <= '0;
      b_q             <= '0;
      j14_q           <= '0;
      j710_q          <= '0;
      is_commit_q     <= 1'b0;
      err_verify_q    <= 1'b0;
      err_run_q       <= 1'b0;
      rdback_q        <= '0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      auto_inc_q      <= auto_inc_d;
      force_bad_par_q <= force_bad_par_d;
      a_q             <= a_d;
      b_q             <= b_d;
      j14_q           <= j14_d;
      j710_q          <= j710_d;
      is_commit_q     <= is_commit_d;
      err_verify_q    <= err_verify_d;
      err_run_q       <= err_run_d;
      rdback_q        <= rdback_d;
    end
  end

  always_comb begin
    // NOTE: every variable gets a hold-value default first, so no path through
    // the case statements can leave one unassigned and infer a latch.
    state_d         = state_q;
    addr_d          = addr_q;
    auto_inc_d      = auto_inc_q;
    force_bad_par_d = force_bad_par_q;
    a_d             = a_q;
    b_d             = b_q;
    j14_d           = j14_q;
    j710_d          = j710_q;
    is_commit_d     = is_commit_q;
    err_verify_d    = err_verify_q;
    err_run_d       = err_run_q;
    rdback_d        = rdback_q;

    unique case (state_q)
      ST_IDLE: begin
        // Strobes are only honoured here; while busy they are dropped whole.
        if (bus.diag_load_func_05x) begin
          case (sub)
            SUB_LD_ADR: begin
              addr_d          = bus.ebus_data[F_ADR_LO:F_ADR_HI];
              auto_inc_d      = bus.ebus_data[F_AUTOINC];
              force_bad_par_d = bus.ebus_data[F_BADPAR];
            end
            SUB_LD_AB: begin
              a_d = bus.ebus_data[F_A_LO:F_A_HI];
              b_d = bus.ebus_data[F_B_LO:F_B_HI];
            end
            SUB_LD_J14: j14_d = bus.ebus_data[F_J_LO:F_J_HI];
            SUB_LD_J7_COMMIT: begin
              j710_d = bus.ebus_data[F_J_LO:F_J_HI];
              if (bus.cpu_run) begin
                err_run_d = 1'b1;
              end else begin
                state_d     = ST_WRITE;
                is_commit_d = 1'b1;
              end
            end
            SUB_CLR_ERR: begin
              err_verify_d = 1'b0;
              err_run_d    = 1'b0;
            end
            SUB_RD: begin
              if (!bus.cpu_run) begin
                state_d     = ST_READ;
                is_commit_d = 1'b0;
              end
            end
            default: ;
          endcase
        end
      end
      ST_WRITE: state_d = ST_READ;
      ST_READ:  state_d = ST_VERIFY;
      ST_VERIFY: begin
        rdback_d = bus.dram_dout;
        if (is_commit_q && (bus.dram_dout != word)) begin
          err_verify_d = 1'b1;
        end
        if (auto_inc_q) begin
          addr_d = addr_q + dram_addr_t'(1);
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.dram_own   = (state_q != ST_IDLE);
  assign bus.busy       = (state_q != ST_IDLE);
  assign bus.dram_we    = (state_q == ST_WRITE);
  assign bus.dram_din   = (state_q == ST_WRITE) ? word : '0;
  assign bus.dram_addr  = (state_q != ST_IDLE) ? addr_q : '0;
  assign bus.err_verify = err_verify_q;
  assign bus.err_run    = err_run_q;
  assign bus.rdback     = rdback_q;

endmodule

// File: tb/tb_dram_loader.sv
// Bench for dram_loader: behavioural DRAM with stuck-bit injection, a timeline
// model of the loader, a per-cycle compare process and literal spot checks.
module tb_dram_loader;
  import dram_loader_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dram_loader_if bus ();

  dram_loader dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // Behavioural synchronous DRAM; stuck bits are ORed into every write.
  dram_word_t ram [DRAM_SIZE];
  dram_word_t ram_dout = '0;
  dram_word_t stuck = '0;
  always @(posedge clk) begin
    if (bus.dram_we) ram[bus.dram_addr] <= bus.dram_din | stuck;
    ram_dout <= ram[bus.dram_addr];
  end
  assign bus.dram_dout = ram_dout;

  // ---------------- model ----------------
  typedef struct {
    int         at;
    int         kind;   // 0 rdback, 1 err_verify, 2 err_run
    dram_word_t val;
  } ev_t;
  ev_t evq[$];

  dram_word_t m_mem [DRAM_SIZE];
  logic [8:0] m_addr;
  logic       m_auto, m_fbp;
  logic [2:0] m_a, m_b;
  logic [3:0] m_j14, m_j710;
  int         seq_start, seq_len;
  logic       seq_commit;
  logic [8:0] seq_addr;
  dram_word_t seq_word;
  dram_word_t m_rdback;
  logic       m_errv, m_errr;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic dram_word_t model_word();
    logic [13:0] data;
    logic        p;
    data = {m_a, m_b, m_j14, m_j710};
    p = ($countones(data) % 2 == 0) ? 1'b1 : 1'b0;
    if (m_fbp) p = ~p;
    return {m_a, m_b, p, m_j14, m_j710};
  endfunction

  function automatic void model_reset();
    m_addr = '0; m_auto = 1'b0; m_fbp = 1'b0;
    m_a = '0; m_b = '0; m_j14 = '0; m_j710 = '0;
    seq_start = -100; seq_len = 0; seq_commit = 1'b0;
    seq_addr = '0; seq_word = '0;
    m_rdback = '0; m_errv = 1'b0; m_errr = 1'b0;
    evq.delete();
  endfunction

  function automatic void push_ev(input int at, input int kind, input dram_word_t val);
    ev_t e;
    e.at = at; e.kind = kind; e.val = val;
    evq.push_back(e);
  endfunction

  function automatic void model_start(input int n, input logic commit);
    dram_word_t stored;
    seq_start  = n;
    seq_commit = commit;
    seq_len    = commit ? 3 : 2;
    seq_addr   = m_addr;
    seq_word   = model_word();
    if (commit) begin
      stored = seq_word | stuck;
      m_mem[m_addr] = stored;
      push_ev(n + 4, 0, stored);
      if (stored != seq_word) push_ev(n + 4, 1, 15'd1);
    end else begin
      push_ev(n + 3, 0, m_mem[m_addr]);
    end
    if (m_auto) m_addr = m_addr + 9'd1;
  endfunction

  function automatic void model_step(input int n, input diag_sub_e sub, input ebus_word_t eb,
                                     input logic run);
    if (n >= seq_start + 1 && n <= seq_start + seq_len) return;
    case (sub)
      SUB_LD_ADR: begin
        m_addr = eb[27:35]; m_auto = eb[0]; m_fbp = eb[1];
      end
      SUB_LD_AB: begin
        m_a = eb[0:2]; m_b = eb[3:5];
      end
      SUB_LD_J14: m_j14 = eb[0:3];
      SUB_LD_J7_COMMIT: begin
        m_j710 = eb[0:3];
        if (run) push_ev(n + 1, 2, 15'd1);
        else     model_start(n, 1'b1);
      end
      SUB_CLR_ERR: begin
        push_ev(n + 1, 1, 15'd0);
        push_ev(n + 1, 2, 15'd0);
      end
      SUB_RD: if (!run) model_start(n, 1'b0);
      default: ;
    endcase
  endfunction

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      int   rel;
      logic e_busy, e_we;
      @(negedge clk);
      while (evq.size() > 0 && evq[0].at <= cyc) begin
        case (evq[0].kind)
          0:       m_rdback = evq[0].val;
          1:       m_errv   = evq[0].val[14];
          default: m_errr   = evq[0].val[14];
        endcase
        void'(evq.pop_front());
      end
      rel    = cyc - seq_start;
      e_busy = (rel >= 1 && rel <= seq_len);
      e_we   = seq_commit && rel == 1;
      check("busy", bus.busy, e_busy);
      check("own", bus.dram_own, e_busy);
      check("we", bus.dram_we, e_we);
      if (e_busy) check("addr", bus.dram_addr, seq_addr);
      if (e_we)   check("din", bus.dram_din, seq_word);
      check("rdback", bus.rdback, m_rdback);
      check("err_verify", bus.err_verify, m_errv);
      check("err_run", bus.err_run, m_errr);
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      #2;
    end
  endtask

  task automatic do_strobe(input diag_sub_e sub, input ebus_word_t eb);
    @(negedge clk);
    #2;
    bus.diag_load_func_05x = 1'b1;
    bus.diag_sel  = sub;
    bus.ebus_data = eb;
    model_step(cyc, sub, eb, bus.cpu_run);
    @(negedge clk);
    #2;
    bus.diag_load_func_05x = 1'b0;
    bus.ebus_data = '0;
  endtask

  task automatic ld_adr(input logic [8:0] a, input logic ai, input logic fbp);
    ebus_word_t e;
    e = '0; e[27:35] = a; e[0] = ai; e[1] = fbp;
    do_strobe(SUB_LD_ADR, e);
  endtask

  task automatic ld_ab(input logic [2:0] a, input logic [2:0] b);
    ebus_word_t e;
    e = '0; e[0:2] = a; e[3:5] = b;
    do_strobe(SUB_LD_AB, e);
  endtask

  task automatic ld_j(input diag_sub_e sub, input logic [3:0] j);
    ebus_word_t e;
    e = '0; e[0:3] = j;
    do_strobe(sub, e);
  endtask

  initial begin
    bus.diag_load_func_05x = 1'b0;
    bus.diag_sel  = '0;
    bus.ebus_data = '0;
    bus.cpu_run   = 1'b0;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_we", bus.dram_we, 0);
    check("rst_own", bus.dram_own, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_rdback", bus.rdback, 0);
    wait_cycles(2);
    rst_n = 1'b1;
    wait_cycles(1);

    // Basic commit at 0o254.
    ld_adr(9'o254, 1'b0, 1'b0);
    ld_ab(3'd3, 3'd5);
    ld_j(SUB_LD_J14, 4'hA);
    ld_j(SUB_LD_J7_COMMIT, 4'h6);
    check("basic_we", bus.dram_we, 1);
    check("basic_din", bus.dram_din, 15'b011101110100110);
    check("basic_addr", bus.dram_addr, 172);
    wait_cycles(3);
    check("basic_rdback", bus.rdback, 15'b011101110100110);
    check("basic_errv", bus.err_verify, 0);

    // Readback-only of the same word.
    do_strobe(SUB_RD, '0);
    check("rd_no_we", bus.dram_we, 0);
    wait_cycles(2);
    check("rd_rdback", bus.rdback, 15'b011101110100110);

    // Auto-increment wrap 511 -> 0.
    ld_adr(9'd511, 1'b1, 1'b0);
    ld_ab(3'd1, 3'd2);
    ld_j(SUB_LD_J14, 4'h3);
    ld_j(SUB_LD_J7_COMMIT, 4'h4);
    check("wrap_addr511", bus.dram_addr, 511);
    wait_cycles(3);
    ld_j(SUB_LD_J7_COMMIT, 4'h7);
    check("wrap_addr0", bus.dram_addr, 0);
    check("wrap_we", bus.dram_we, 1);
    wait_cycles(3);

    // Forced bad parity: stored word has even total parity, no verify error.
    ld_adr(9'o100, 1'b0, 1'b1);
    ld_j(SUB_LD_J7_COMMIT, 4'h5);
    wait_cycles(3);
    check("badpar_even", ^bus.rdback, 0);
    check("badpar_errv", bus.err_verify, 0);

    // Commit while CPU running.
    bus.cpu_run = 1'b1;
    ld_j(SUB_LD_J7_COMMIT, 4'h1);
    check("run_no_we", bus.dram_we, 0);
    check("run_err", bus.err_run, 1);
    do_strobe(SUB_RD, '0);
    check("run_rd_busy", bus.busy, 0);
    bus.cpu_run = 1'b0;
    do_strobe(SUB_CLR_ERR, '0);
    check("clr_err_run", bus.err_run, 0);

    // LD_AB while busy is ignored; cpu_run rising mid-sequence does not abort.
    ld_adr(9'o300, 1'b0, 1'b0);
    ld_ab(3'd2, 3'd6);
    ld_j(SUB_LD_J14, 4'h1);
    ld_j(SUB_LD_J7_COMMIT, 4'hF);
    ld_ab(3'd7, 3'd7);
    bus.cpu_run = 1'b1;
    wait_cycles(2);
    bus.cpu_run = 1'b0;
    ld_j(SUB_LD_J7_COMMIT, 4'hF);
    check("busy_ab_din", bus.dram_din, 15'b010110100011111);
    wait_cycles(3);

    // Stuck-at-1 on bit 14 of the DRAM.
    ld_adr(9'o5, 1'b0, 1'b0);
    ld_ab(3'd0, 3'd0);
    ld_j(SUB_LD_J14, 4'h0);
    stuck = 15'b000000000000001;
    ld_j(SUB_LD_J7_COMMIT, 4'h0);
    check("stuck_din", bus.dram_din, 15'b000000100000000);
    wait_cycles(2);
    check("stuck_errv_early", bus.err_verify, 0);
    wait_cycles(1);
    check("stuck_errv", bus.err_verify, 1);
    check("stuck_rdback", bus.rdback, 15'b000000100000001);
    stuck = '0;
    do_strobe(SUB_CLR_ERR, '0);
    check("clr_errv", bus.err_verify, 0);

    // Reset pulse at N+2 of a commit.
    ld_adr(9'o40, 1'b0, 1'b0);
    ld_ab(3'd1, 3'd1);
    ld_j(SUB_LD_J14, 4'h1);
    ld_j(SUB_LD_J7_COMMIT, 4'h1);
    wait_cycles(1);
    check("pre_rst_busy", bus.busy, 1);
    rst_n = 1'b0;
    model_reset();
    #1;
    check("midrst_we", bus.dram_we, 0);
    check("midrst_own", bus.dram_own, 0);
    check("midrst_busy", bus.busy, 0);
    check("midrst_addr", bus.dram_addr, 0);
    check("midrst_din", bus.dram_din, 0);
    wait_cycles(1);
    rst_n = 1'b1;
    wait_cycles(2);
    check("post_rst_busy", bus.busy, 0);

    // Fresh commit after reset: fields and address back at zero.
    ld_j(SUB_LD_J7_COMMIT, 4'h0);
    check("post_rst_din", bus.dram_din, 15'b000000100000000);
    check("post_rst_addr", bus.dram_addr, 0);
    wait_cycles(3);
    check("post_rst_rdback", bus.rdback, 15'b000000100000000);
    wait_cycles(2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
